// File: rtl/fsm_ctx_sched_pkg.sv
// fsm_ctx_pkg: shared types and rules for the time-multiplexed sequence detector.
//   state_t     - 2-bit detector state (S0_0..S1_1)
//   next_state  - transition rule applied to one channel context
//   out_map     - 2-bit output from the pre-update state and input vector
package fsm_ctx_pkg;

    localparam int unsigned N_IN  = 4;
    localparam int unsigned M_OUT = 2;

    typedef enum logic [1:0] {
        S0_0 = 2'b00,
        S0_1 = 2'b01,
        S1_0 = 2'b10,
        S1_1 = 2'b11
    } state_t;

    function automatic state_t next_state(state_t s, logic [N_IN-1:0] x);
        state_t n;
        n = s;
        unique case (s)
            S0_0: if (x[2]) n = S0_1;
            S0_1: if (x[1]) n = S1_0;
            S1_0: if (x[2]) n = S1_1;
            S1_1: if (x[0]) n = S0_0;
            default: n = s;
        endcase
        return n;
    endfunction

    function automatic logic [M_OUT-1:0] out_map(state_t s, logic [N_IN-1:0] x);
        logic [M_OUT-1:0] o;
        o = '0;
        unique case (s)
            S0_0: o = {x[0], x[1]};
            S0_1: o = {x[3], x[2]};
            S1_0: o = {x[0], x[3]};
            S1_1: o = {x[1], x[2]};
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/fsm_ctx_sched_if.sv
// fsm_ctx_sched_if: request/response bundle of the context scheduler.
//   req_valid/req_in/ctx_clr/rsp_ready : driven by requesters and consumer (master)
//   req_ready/rsp_*                    : driven by the scheduler (slave)
interface fsm_ctx_sched_if
    import fsm_ctx_pkg::*;
#(
    parameter int unsigned N_CH = 4
) ();
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]      req_valid;
    logic [N_CH*N_IN-1:0] req_in;
    logic [N_CH-1:0]      req_ready;
    logic [N_CH-1:0]      ctx_clr;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [CH_W-1:0]      rsp_ch;
    logic [M_OUT-1:0]     rsp_out;
    logic [1:0]           rsp_state;
    logic                 rsp_wrap;

    modport master (
        output req_valid, req_in, ctx_clr, rsp_ready,
        input  req_ready, rsp_valid, rsp_ch, rsp_out, rsp_state, rsp_wrap
    );

    modport slave (
        input  req_valid, req_in, ctx_clr, rsp_ready,
        output req_ready, rsp_valid, rsp_ch, rsp_out, rsp_state, rsp_wrap
    );
endinterface

// File: rtl/fsm_ctx_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req     - request vector
//   ptr     - channel with highest priority this cycle
//   adv     - grant may be issued (downstream can take it)
//   gnt     - one-hot grant, zero when adv is low or nothing requested
//   gnt_idx - index of the selected channel
//   gnt_any - a grant was issued
module rr_arbiter #(
    parameter  int unsigned N = 4,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         adv,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_any
);
    localparam logic [W:0] N_W = (W+1)'(N);

    logic [W:0] idx;
    logic       found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (W+1)'(k);
            if (idx >= N_W) idx = idx - N_W;
            if (!found && req[idx[W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = idx[W-1:0];
            end
        end
        gnt_any = found & adv;
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end
endmodule

// File: rtl/fsm_ctx_sched.sv
// fsm_ctx_sched: shares one 4-state detector among N_CH channel contexts.
//   clk, rst - clock, synchronous active-high reset
//   bus      - request side (req_valid/req_in/req_ready/ctx_clr) and the
//              one-deep registered response slot (rsp_*) with rsp_ready backpressure
module fsm_ctx_sched
    import fsm_ctx_pkg::*;
#(
    parameter int unsigned N_CH = 4
) (
    input logic            clk,
    input logic            rst,
    fsm_ctx_sched_if.slave bus
);
    localparam int unsigned     CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    state_t           ctx_q [N_CH];
    state_t           ctx_d [N_CH];
    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [CH_W-1:0]  rsp_ch_q, rsp_ch_d;
    logic [M_OUT-1:0] rsp_out_q, rsp_out_d;
    state_t           rsp_state_q, rsp_state_d;
    logic             rsp_wrap_q, rsp_wrap_d;

    logic [N_CH-1:0]  eligible;
    logic [N_CH-1:0]  gnt;
    logic [CH_W-1:0]  gnt_idx;
    logic             accept;
    logic             slot_free;
    state_t           cur_state, nxt_state;
    logic [N_IN-1:0]  cur_in;

    assign eligible  = bus.req_valid & ~bus.ctx_clr;
    assign slot_free = ~rsp_valid_q | bus.rsp_ready;

    rr_arbiter #(.N(N_CH)) u_arb (
        .req     (eligible),
        .ptr     (rr_ptr_q),
        .adv     (slot_free & ~rst),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (accept)
    );

    always_comb begin
        cur_state = S0_0;
        cur_in    = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (gnt[i]) begin
                cur_state = ctx_q[i];
                cur_in    = bus.req_in[i*N_IN +: N_IN];
            end
        end
        nxt_state = next_state(cur_state, cur_in);

        // Clear wins; a cleared channel is never eligible, so it cannot also be granted.
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (bus.ctx_clr[i])  ctx_d[i] = S0_0;
            else if (gnt[i])     ctx_d[i] = nxt_state;
            else                 ctx_d[i] = ctx_q[i];
        end

        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_ch_d    = rsp_ch_q;
        rsp_out_d   = rsp_out_q;
        rsp_state_d = rsp_state_q;
        rsp_wrap_d  = rsp_wrap_q;
        if (accept) begin
            rr_ptr_d    = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
            rsp_valid_d = 1'b1;
            rsp_ch_d    = gnt_idx;
            rsp_out_d   = out_map(cur_state, cur_in);
            rsp_state_d = nxt_state;
            rsp_wrap_d  = (cur_state == S1_1) && (nxt_state == S0_0);
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CH; i++) ctx_q[i] <= S0_0;
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ch_q    <= '0;
            rsp_out_q   <= '0;
            rsp_state_q <= S0_0;
            rsp_wrap_q  <= 1'b0;
        end else begin
            ctx_q       <= ctx_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ch_q    <= rsp_ch_d;
            rsp_out_q   <= rsp_out_d;
            rsp_state_q <= rsp_state_d;
            rsp_wrap_q  <= rsp_wrap_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_ch    = rsp_ch_q;
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_state = rsp_state_q;
    assign bus.rsp_wrap  = rsp_wrap_q;
endmodule
